// File: rtl/mio_arbiter.sv
// Two-master (CPU / DMA) arbiter for a single shared memory/IO bus with a completion timeout.
// Optional round-robin tie-break on simultaneous requests: define MIO_ARB_ROUND_ROBIN_EN.
module mio_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [1:0]  grant,
  output logic        bus_err
);

  localparam int unsigned CNT_W   = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam int unsigned TO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
  localparam logic [1:0]  GNT_NONE = 2'b00;
  localparam logic [1:0]  GNT_CPU  = 2'b01;
  localparam logic [1:0]  GNT_DMA  = 2'b10;
  localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_DONE} state_e;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [1:0]        grant_q, grant_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic              dma_ready_q, dma_ready_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic [31:0]       dma_rdata_q, dma_rdata_d;
  logic              bus_err_q, bus_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pick_cpu;
  logic              timeout;
  logic              finish;
  logic [31:0]       fin_data;

`ifdef MIO_ARB_ROUND_ROBIN_EN
  logic last_dma_q, last_dma_d;
  // On a tie, the requester that did not own the bus last time wins.
  assign pick_cpu = cpu_req && (!dma_req || last_dma_q);
`else
  assign pick_cpu = cpu_req;
`endif

  // Final XFER cycle: the count reaches TIMEOUT_CYC at this edge.
  assign timeout  = (cnt_q >= CNT_W'(TO_LAST));
  assign finish   = mem_ready || timeout;
  assign fin_data = mem_ready ? mem_rdata : ERR_DATA;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      grant_q     <= GNT_NONE;
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      bus_err_q   <= 1'b0;
      cnt_q       <= '0;
`ifdef MIO_ARB_ROUND_ROBIN_EN
      last_dma_q  <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      grant_q     <= grant_d;
      cpu_ready_q <= cpu_ready_d;
      dma_ready_q <= dma_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      bus_err_q   <= bus_err_d;
      cnt_q       <= cnt_d;
`ifdef MIO_ARB_ROUND_ROBIN_EN
      last_dma_q  <= last_dma_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    grant_d     = grant_q;
    cpu_ready_d = 1'b0;
    dma_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    bus_err_d   = 1'b0;
    cnt_d       = cnt_q;
`ifdef MIO_ARB_ROUND_ROBIN_EN
    last_dma_d  = last_dma_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cpu_req || dma_req) begin
          state_d   = ST_XFER;
          mem_req_d = 1'b1;
          cnt_d     = '0;
          if (pick_cpu) begin
            mem_we_d    = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            grant_d     = GNT_CPU;
`ifdef MIO_ARB_ROUND_ROBIN_EN
            last_dma_d  = 1'b0;
`endif
          end else begin
            mem_we_d    = dma_we;
            mem_addr_d  = dma_addr;
            mem_wdata_d = dma_wdata;
            grant_d     = GNT_DMA;
`ifdef MIO_ARB_ROUND_ROBIN_EN
            last_dma_d  = 1'b1;
`endif
          end
        end
      end

      ST_XFER: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A real completion outranks a timeout landing on the same cycle.
        if (finish) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          grant_d   = GNT_NONE;
          bus_err_d = !mem_ready;
          if (grant_q == GNT_CPU) begin
            cpu_rdata_d = fin_data;
            cpu_ready_d = 1'b1;
          end else begin
            dma_rdata_d = fin_data;
            dma_ready_d = 1'b1;
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign grant     = grant_q;
  assign cpu_ready = cpu_ready_q;
  assign dma_ready = dma_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mio_arbiter.sv
// Directed bench for mio_arbiter (default fixed-priority build, TIMEOUT_CYC=4).
module tb_mio_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we, mem_ready;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic        cpu_ready, dma_ready, mem_req, mem_we, bus_err;
  logic [1:0]  grant;

  int total = 0;
  int bad   = 0;

  mio_arbiter #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ready(dma_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant(grant), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        c_req;
    logic [31:0] c_addr;
    logic        d_req;
    logic [31:0] d_addr;
    logic        m_rdy;
    logic [31:0] m_rd;
    logic [1:0]  e_grant;
    logic        e_mreq;
    logic [31:0] e_addr;
    logic        e_crdy;
    logic        e_drdy;
    logic [31:0] e_crd;
    logic [31:0] e_drd;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic c, input logic [31:0] ca, input logic d,
                              input logic [31:0] da, input logic mr, input logic [31:0] rd,
                              input logic [1:0] g, input logic mq, input logic [31:0] ea,
                              input logic cr, input logic dr,
                              input logic [31:0] crd, input logic [31:0] drd);
    vec_t v;
    v.c_req = c;  v.c_addr = ca; v.d_req = d; v.d_addr = da;
    v.m_rdy = mr; v.m_rd = rd;   v.e_grant = g; v.e_mreq = mq; v.e_addr = ea;
    v.e_crdy = cr; v.e_drdy = dr; v.e_crd = crd; v.e_drd = drd;
    return v;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, " mem_req"},   32'(mem_req),   32'd0);
    chk({tag, " mem_we"},    32'(mem_we),    32'd0);
    chk({tag, " mem_addr"},  mem_addr,       32'd0);
    chk({tag, " mem_wdata"}, mem_wdata,      32'd0);
    chk({tag, " grant"},     32'(grant),     32'd0);
    chk({tag, " cpu_ready"}, 32'(cpu_ready), 32'd0);
    chk({tag, " dma_ready"}, 32'(dma_ready), 32'd0);
    chk({tag, " cpu_rdata"}, cpu_rdata,      32'd0);
    chk({tag, " dma_rdata"}, dma_rdata,      32'd0);
    chk({tag, " bus_err"},   32'(bus_err),   32'd0);
  endtask

  initial begin
    // Rows: inputs during a cycle, outputs expected during that same cycle.
    tbl[0]  = mk(1, 32'h10, 0, 32'h400, 0, 0,            2'b00, 0, 0,      0, 0, 0,            0);
    tbl[1]  = mk(1, 32'h10, 0, 32'h400, 0, 0,            2'b01, 1, 32'h10, 0, 0, 0,            0);
    tbl[2]  = mk(1, 32'h10, 0, 32'h400, 0, 0,            2'b01, 1, 32'h10, 0, 0, 0,            0);
    tbl[3]  = mk(1, 32'h10, 0, 32'h400, 0, 0,            2'b01, 1, 32'h10, 0, 0, 0,            0);
    tbl[4]  = mk(1, 32'h10, 0, 32'h400, 1, 32'h12345678, 2'b01, 1, 32'h10, 0, 0, 0,            0);
    tbl[5]  = mk(0, 32'h10, 0, 32'h400, 0, 0,            2'b00, 0, 0,      1, 0, 32'h12345678, 0);
    tbl[6]  = mk(0, 32'h10, 0, 32'h400, 1, 32'hFFFF0000, 2'b00, 0, 0,      0, 0, 32'h12345678, 0);
    tbl[7]  = mk(1, 32'h20, 1, 32'h400, 0, 0,            2'b00, 0, 0,      0, 0, 32'h12345678, 0);
    tbl[8]  = mk(1, 32'h20, 1, 32'h400, 0, 0,            2'b01, 1, 32'h20, 0, 0, 32'h12345678, 0);
    tbl[9]  = mk(1, 32'h20, 1, 32'h400, 1, 32'h1111,     2'b01, 1, 32'h20, 0, 0, 32'h12345678, 0);
    tbl[10] = mk(0, 32'h20, 1, 32'h400, 1, 32'h9999,     2'b00, 0, 0,      1, 0, 32'h1111,     0);
    tbl[11] = mk(0, 32'h20, 1, 32'h400, 0, 0,            2'b00, 0, 0,      0, 0, 32'h1111,     0);
    tbl[12] = mk(1, 32'h20, 1, 32'h400, 0, 0,            2'b10, 1, 32'h400,0, 0, 32'h1111,     0);
    tbl[13] = mk(1, 32'h20, 1, 32'h400, 1, 32'h2222,     2'b10, 1, 32'h400,0, 0, 32'h1111,     0);
    tbl[14] = mk(1, 32'h20, 0, 32'h400, 0, 0,            2'b00, 0, 0,      0, 1, 32'h1111,     32'h2222);
    tbl[15] = mk(1, 32'h20, 0, 32'h400, 0, 0,            2'b00, 0, 0,      0, 0, 32'h1111,     32'h2222);
    tbl[16] = mk(1, 32'h20, 0, 32'h400, 0, 0,            2'b01, 1, 32'h20, 0, 0, 32'h1111,     32'h2222);
    tbl[17] = mk(1, 32'h20, 0, 32'h400, 1, 32'h3333,     2'b01, 1, 32'h20, 0, 0, 32'h1111,     32'h2222);
    tbl[18] = mk(0, 32'h20, 0, 32'h400, 0, 0,            2'b00, 0, 0,      1, 0, 32'h3333,     32'h2222);
    tbl[19] = mk(0, 32'h20, 0, 32'h400, 0, 0,            2'b00, 0, 0,      0, 0, 32'h3333,     32'h2222);

    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 32'hA5A5_0001;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 32'h5A5A_0002;
    mem_ready = 0; mem_rdata = 0;
    #1 chk_all_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("r%0d grant", i),     32'(grant),     32'(tbl[i].e_grant));
      chk($sformatf("r%0d mem_req", i),   32'(mem_req),   32'(tbl[i].e_mreq));
      chk($sformatf("r%0d cpu_ready", i), 32'(cpu_ready), 32'(tbl[i].e_crdy));
      chk($sformatf("r%0d dma_ready", i), 32'(dma_ready), 32'(tbl[i].e_drdy));
      chk($sformatf("r%0d bus_err", i),   32'(bus_err),   32'd0);
      chk($sformatf("r%0d cpu_rdata", i), cpu_rdata,      tbl[i].e_crd);
      chk($sformatf("r%0d dma_rdata", i), dma_rdata,      tbl[i].e_drd);
      if (tbl[i].e_mreq) chk($sformatf("r%0d mem_addr", i), mem_addr, tbl[i].e_addr);
      cpu_req = tbl[i].c_req; cpu_addr = tbl[i].c_addr;
      dma_req = tbl[i].d_req; dma_addr = tbl[i].d_addr;
      mem_ready = tbl[i].m_rdy; mem_rdata = tbl[i].m_rd;
    end

    // Timeout: no mem_ready, four XFER cycles then error completion.
    @(negedge clk);
    cpu_req = 1; cpu_addr = 32'h44; mem_ready = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("to%0d mem_req", k),   32'(mem_req),   32'd1);
      chk($sformatf("to%0d bus_err", k),   32'(bus_err),   32'd0);
      chk($sformatf("to%0d cpu_ready", k), 32'(cpu_ready), 32'd0);
    end
    @(negedge clk);
    chk("to bus_err",   32'(bus_err),   32'd1);
    chk("to cpu_ready", 32'(cpu_ready), 32'd1);
    chk("to dma_ready", 32'(dma_ready), 32'd0);
    chk("to cpu_rdata", cpu_rdata,      32'hFFFF_FFFF);
    chk("to mem_req",   32'(mem_req),   32'd0);
    chk("to grant",     32'(grant),     32'd0);
    cpu_req = 0;
    @(negedge clk);
    chk("to bus_err end",   32'(bus_err),   32'd0);
    chk("to cpu_ready end", 32'(cpu_ready), 32'd0);

    // DMA write held stable while the CPU asks mid-transfer.
    dma_req = 1; dma_we = 1; dma_addr = 32'h400; dma_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("dw grant", 32'(grant), 32'b10);
    chk("dw we",    32'(mem_we), 32'd1);
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h80; cpu_wdata = 32'hCAFE_F00D;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("dw%0d grant", k), 32'(grant), 32'b10);
      chk($sformatf("dw%0d mem_req", k), 32'(mem_req), 32'd1);
      chk($sformatf("dw%0d addr", k),  mem_addr,  32'h400);
      chk($sformatf("dw%0d wdata", k), mem_wdata, 32'hDEAD_BEEF);
    end
    mem_ready = 1; mem_rdata = 32'h0;
    @(negedge clk);
    mem_ready = 0;
    chk("dw dma_ready", 32'(dma_ready), 32'd1);
    chk("dw cpu_ready", 32'(cpu_ready), 32'd0);
    chk("dw done grant", 32'(grant), 32'd0);
    dma_req = 0; dma_we = 0;
    @(negedge clk);
    chk("dw idle grant",   32'(grant),   32'd0);
    chk("dw idle mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("cw grant", 32'(grant),    32'b01);
    chk("cw addr",  mem_addr,      32'h80);
    chk("cw wdata", mem_wdata,     32'hCAFE_F00D);
    chk("cw we",    32'(mem_we),   32'd1);
    mem_ready = 1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    mem_ready = 0;
    chk("cw cpu_ready", 32'(cpu_ready), 32'd1);
    chk("cw cpu_rdata", cpu_rdata,      32'h5555_AAAA);
    cpu_req = 0; cpu_we = 0;
    @(negedge clk);

    // Asynchronous reset in the middle of a CPU read.
    cpu_req = 1; cpu_addr = 32'h10;
    @(negedge clk);
    chk("rs xfer mem_req", 32'(mem_req), 32'd1);
    #2 reset = 1'b0;
    #1 chk_all_zero("rs async");
    mem_ready = 1; mem_rdata = 32'h77;
    @(negedge clk);
    chk("rs held cpu_ready", 32'(cpu_ready), 32'd0);
    chk("rs held mem_req",   32'(mem_req),   32'd0);
    reset = 1'b1; mem_ready = 0;
    @(negedge clk);
    chk("rs post grant",     32'(grant),     32'b01);
    chk("rs post mem_req",   32'(mem_req),   32'd1);
    chk("rs post addr",      mem_addr,       32'h10);
    chk("rs post cpu_ready", 32'(cpu_ready), 32'd0);
    mem_ready = 1; mem_rdata = 32'hABCD_0123;
    @(negedge clk);
    mem_ready = 0;
    chk("rs post done ready", 32'(cpu_ready), 32'd1);
    chk("rs post done rdata", cpu_rdata,      32'hABCD_0123);
    cpu_req = 0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
